// File: rtl/sd_init_seq.sv
// sd_init_seq: SD card identification and bus-setup sequencer.
// Ports: iclk/irst/istart; CMD driver handshake (ostart_cmd, oindex,
// oarg, icmd_done, iresp); status (osel_clk, ordy, ofail, ofail_code, orca).
module sd_init_seq #(
  parameter int RESP_TIMEOUT = 65535,
  parameter int ACMD41_TRIES = 1000,
  parameter int POLL_GAP     = 36000
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic        istart,
  output logic        ostart_cmd,
  output logic [5:0]  oindex,
  output logic [31:0] oarg,
  input  logic        icmd_done,
  input  logic [31:0] iresp,
  output logic        osel_clk,
  output logic        ordy,
  output logic        ofail,
  output logic [2:0]  ofail_code,
  output logic [15:0] orca
);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD0, S_CMD8, S_A55, S_ACMD41, S_GAP, S_CMD2,
    S_CMD3, S_CMD7, S_B55, S_ACMD6, S_DONE, S_FAIL
  } state_t;

  // Terminal counts: last wait cycle, try limit, last gap cycle.
  localparam logic [15:0] WD_END  = 16'(RESP_TIMEOUT - 1);
  localparam logic [9:0]  TRY_END = 10'(ACMD41_TRIES);
  localparam logic [15:0] GAP_END = 16'(POLL_GAP - 1);

  state_t      state_q, state_d;
  logic        wait_q, wait_d;
  logic [15:0] wdog_q, wdog_d;
  logic [15:0] gap_q, gap_d;
  logic [9:0]  tries_q, tries_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] arg_q, arg_d;
  logic [15:0] rca_q, rca_d;
  logic [2:0]  code_q, code_d;
  logic        rdy_q, fail_q, sel_q;
  logic        go;

  function automatic logic is_cmd(state_t s);
    return !(s inside {S_IDLE, S_GAP, S_DONE, S_FAIL});
  endfunction

  function automatic logic [5:0] cmd_idx(state_t s);
    case (s)
      S_CMD8:       return 6'd8;
      S_A55, S_B55: return 6'd55;
      S_ACMD41:     return 6'd41;
      S_CMD2:       return 6'd2;
      S_CMD3:       return 6'd3;
      S_CMD7:       return 6'd7;
      S_ACMD6:      return 6'd6;
      default:      return 6'd0;
    endcase
  endfunction

  function automatic logic [31:0] cmd_arg(
    state_t s, logic [15:0] rca
  );
    case (s)
      S_CMD8:        return 32'h0000_01AA;
      S_ACMD41:      return 32'h40FF_8000;
      S_CMD7, S_B55: return {rca, 16'h0};
      S_ACMD6:       return 32'h0000_0002;
      default:       return 32'h0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    wdog_d  = wdog_q;
    gap_d   = gap_q;
    tries_d = tries_q;
    rca_d   = rca_q;
    code_d  = code_q;
    go      = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (istart) begin
          state_d = S_CMD0;
          go      = 1'b1;
          tries_d = '0;
          rca_d   = '0;
          code_d  = '0;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_END) begin
          state_d = S_A55;
          go      = 1'b1;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: begin
        if (!wait_q) begin
          // Launch cycle: arm the watchdog.
          wait_d = 1'b1;
          wdog_d = '0;
        end else if (icmd_done) begin
          // Done beats a watchdog expiring in the same cycle.
          wait_d = 1'b0;
          unique case (state_q)
            S_CMD0: state_d = S_CMD8;
            S_CMD8: begin
              if (iresp[11:0] == 12'h1AA) begin
                state_d = S_A55;
              end else begin
                state_d = S_FAIL;
                code_d  = 3'd1;
              end
            end
            S_A55, S_B55: begin
              if (iresp[5]) begin
                state_d = (state_q == S_A55) ? S_ACMD41 : S_ACMD6;
              end else begin
                state_d = S_FAIL;
                code_d  = 3'd2;
              end
            end
            S_ACMD41: begin
              if (iresp[31]) begin
                state_d = S_CMD2;
              end else begin
                tries_d = tries_q + 10'd1;
                if (tries_q + 10'd1 == TRY_END) begin
                  state_d = S_FAIL;
                  code_d  = 3'd3;
                end else begin
                  state_d = S_GAP;
                  gap_d   = '0;
                end
              end
            end
            S_CMD2: state_d = S_CMD3;
            S_CMD3: begin
              rca_d   = iresp[31:16];
              state_d = S_CMD7;
            end
            S_CMD7, S_ACMD6: begin
              if (iresp[31:19] == 13'd0) begin
                state_d = (state_q == S_CMD7) ? S_B55 : S_DONE;
              end else begin
                state_d = S_FAIL;
                code_d  = 3'd5;
              end
            end
            default: state_d = S_IDLE;
          endcase
          go = is_cmd(state_d);
        end else if (wdog_q == WD_END) begin
          wait_d  = 1'b0;
          state_d = S_FAIL;
          code_d  = 3'd4;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
    endcase
    // Index/arg latch at launch; CMD7 sees the RCA captured same edge.
    idx_d = go ? cmd_idx(state_d) : idx_q;
    arg_d = go ? cmd_arg(state_d, rca_d) : arg_q;
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q <= S_IDLE;
      wait_q  <= 1'b0;
      wdog_q  <= '0;
      gap_q   <= '0;
      tries_q <= '0;
      idx_q   <= '0;
      arg_q   <= '0;
      rca_q   <= '0;
      code_q  <= '0;
      rdy_q   <= 1'b0;
      fail_q  <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      wdog_q  <= wdog_d;
      gap_q   <= gap_d;
      tries_q <= tries_d;
      idx_q   <= idx_d;
      arg_q   <= arg_d;
      rca_q   <= rca_d;
      code_q  <= code_d;
      rdy_q   <= (state_d == S_DONE);
      sel_q   <= (state_d == S_DONE);
      fail_q  <= (state_d == S_FAIL);
    end
  end

  assign ostart_cmd = is_cmd(state_q) && !wait_q;
  assign oindex     = idx_q;
  assign oarg       = arg_q;
  assign osel_clk   = sel_q;
  assign ordy       = rdy_q;
  assign ofail      = fail_q;
  assign ofail_code = code_q;
  assign orca       = rca_q;

endmodule

// File: tb/tb_sd_init_seq.sv
// tb_sd_init_seq: directed bench for sd_init_seq.
// Instance a uses default parameters, instance b small ones.
module tb_sd_init_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic        sel, rst, start, done;
  logic [31:0] resp;

  logic        ost_a, ost_b, sclk_a, sclk_b;
  logic        rdy_a, rdy_b, fl_a, fl_b;
  logic [5:0]  idx_a, idx_b;
  logic [31:0] arg_a, arg_b;
  logic [2:0]  code_a, code_b;
  logic [15:0] rca_a, rca_b;

  logic        ost, sclk, rdy, fl;
  logic [5:0]  idx;
  logic [31:0] arg;
  logic [2:0]  code;
  logic [15:0] rca;

  sd_init_seq u_a (
    .iclk(clk), .irst(rst), .istart(start & ~sel),
    .ostart_cmd(ost_a), .oindex(idx_a), .oarg(arg_a),
    .icmd_done(done & ~sel), .iresp(resp),
    .osel_clk(sclk_a), .ordy(rdy_a), .ofail(fl_a),
    .ofail_code(code_a), .orca(rca_a)
  );

  sd_init_seq #(
    .RESP_TIMEOUT(100), .ACMD41_TRIES(3), .POLL_GAP(4)
  ) u_b (
    .iclk(clk), .irst(rst), .istart(start & sel),
    .ostart_cmd(ost_b), .oindex(idx_b), .oarg(arg_b),
    .icmd_done(done & sel), .iresp(resp),
    .osel_clk(sclk_b), .ordy(rdy_b), .ofail(fl_b),
    .ofail_code(code_b), .orca(rca_b)
  );

  assign ost  = sel ? ost_b  : ost_a;
  assign sclk = sel ? sclk_b : sclk_a;
  assign rdy  = sel ? rdy_b  : rdy_a;
  assign fl   = sel ? fl_b   : fl_a;
  assign idx  = sel ? idx_b  : idx_a;
  assign arg  = sel ? arg_b  : arg_a;
  assign code = sel ? code_b : code_a;
  assign rca  = sel ? rca_b  : rca_a;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; done = 1'b0; resp = '0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_launch(
    input int max, output bit ok, output int at
  );
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < max; i++) begin
      if (ost) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
      step(1);
    end
  endtask

  task automatic send_done(
    input int dly, input logic [31:0] r, output int d
  );
    step(dly);
    done = 1'b1;
    resp = r;
    d = cyc;
    step(1);
    done = 1'b0;
    resp = '0;
  endtask

  task automatic run_cmd(
    input int max, input logic [31:0] r, output bit ok,
    output logic [5:0] ix, output logic [31:0] ag,
    output int at, output int d
  );
    wait_launch(max, ok, at);
    ix = idx;
    ag = arg;
    d = cyc;
    if (ok) send_done(1, r, d);
  endtask

  task automatic test_reset();
    sel = 1'b0;
    do_reset();
    checks++; if (ost !== 1'b0) begin failures++; $display("FAIL rst_ostart got=%0h exp=0", ost); end
    checks++; if (idx !== 6'd0) begin failures++; $display("FAIL rst_index got=%0d exp=0", idx); end
    checks++; if (arg !== 32'd0) begin failures++; $display("FAIL rst_arg got=%0h exp=0", arg); end
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL rst_rdy got=%0h exp=0", rdy); end
    checks++; if (fl !== 1'b0) begin failures++; $display("FAIL rst_fail got=%0h exp=0", fl); end
    checks++; if (code !== 3'd0) begin failures++; $display("FAIL rst_code got=%0d exp=0", code); end
    checks++; if (rca !== 16'd0) begin failures++; $display("FAIL rst_rca got=%0h exp=0", rca); end
    checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL rst_selclk got=%0h exp=0", sclk); end
  endtask

  task automatic test_nominal();
    logic [5:0] ei [13] = '{0, 8, 55, 41, 55, 41, 55, 41, 2, 3, 7, 55, 6};
    logic [31:0] ea [13] = '{0, 32'h1AA, 0, 32'h40FF8000, 0,
      32'h40FF8000, 0, 32'h40FF8000, 0, 0, 32'h12340000,
      32'h12340000, 32'h2};
    logic [31:0] rs [13] = '{0, 32'h1AA, 32'h20, 32'h00FF8000,
      32'h20, 32'h00FF8000, 32'h20, 32'hC0FF8000, 0,
      32'h12340000, 0, 32'h20, 0};
    int t, exp_at, at, d;
    bit ok;
    logic [5:0] ix;
    logic [31:0] ag;
    sel = 1'b0;
    t = cyc;
    pulse_start();
    exp_at = t + 1;
    for (int i = 0; i < 13; i++) begin
      run_cmd(40000, rs[i], ok, ix, ag, at, d);
      checks++;
      if (!ok) begin failures++; $display("FAIL nom_launch%0d got=none exp=idx%0d", i, ei[i]); break; end
      checks++; if (ix !== ei[i]) begin failures++; $display("FAIL nom_index%0d got=%0d exp=%0d", i, ix, ei[i]); end
      checks++; if (ag !== ea[i]) begin failures++; $display("FAIL nom_arg%0d got=%0h exp=%0h", i, ag, ea[i]); end
      checks++; if (at !== exp_at) begin failures++; $display("FAIL nom_time%0d got=%0d exp=%0d", i, at, exp_at); end
      exp_at = d + 1 + ((ei[i] == 6'd41 && !rs[i][31]) ? 36000 : 0);
    end
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL nom_rdy got=%0h exp=1", rdy); end
    checks++; if (sclk !== 1'b1) begin failures++; $display("FAIL nom_selclk got=%0h exp=1", sclk); end
    checks++; if (rca !== 16'h1234) begin failures++; $display("FAIL nom_rca got=%0h exp=1234", rca); end
    checks++; if (fl !== 1'b0) begin failures++; $display("FAIL nom_fail got=%0h exp=0", fl); end
    checks++; if (idx !== 6'd6 || arg !== 32'h2) begin failures++; $display("FAIL nom_hold got=%0d/%0h exp=6/2", idx, arg); end
  endtask

  task automatic test_cmd8_mismatch();
    int at, d, n;
    bit ok;
    logic [5:0] ix;
    logic [31:0] ag;
    sel = 1'b1;
    do_reset();
    pulse_start();
    run_cmd(20, 32'h0, ok, ix, ag, at, d);
    run_cmd(20, 32'h1AB, ok, ix, ag, at, d);
    checks++; if (!ok || ix !== 6'd8) begin failures++; $display("FAIL c8_index got=%0d exp=8", ix); end
    checks++; if (fl !== 1'b1) begin failures++; $display("FAIL c8_fail got=%0h exp=1", fl); end
    checks++; if (code !== 3'd1) begin failures++; $display("FAIL c8_code got=%0d exp=1", code); end
    n = 0;
    repeat (50) begin
      if (ost) n++;
      step(1);
    end
    checks++; if (n !== 0) begin failures++; $display("FAIL c8_quiet got=%0d exp=0", n); end
  endtask

  task automatic test_acmd41_exhaust();
    int at, d, exp_at, n;
    bit ok;
    logic [5:0] ix;
    logic [31:0] ag;
    sel = 1'b1;
    do_reset();
    pulse_start();
    run_cmd(20, 32'h0, ok, ix, ag, at, d);
    run_cmd(20, 32'h1AA, ok, ix, ag, at, d);
    exp_at = d + 1;
    for (int k = 0; k < 3; k++) begin
      run_cmd(50, 32'h20, ok, ix, ag, at, d);
      checks++; if (!ok || ix !== 6'd55) begin failures++; $display("FAIL ex_a55_%0d got=%0d exp=55", k, ix); end
      checks++; if (at !== exp_at) begin failures++; $display("FAIL ex_gap%0d got=%0d exp=%0d", k, at, exp_at); end
      run_cmd(50, 32'h00FF8000, ok, ix, ag, at, d);
      checks++; if (!ok || ix !== 6'd41) begin failures++; $display("FAIL ex_a41_%0d got=%0d exp=41", k, ix); end
      exp_at = d + 5;
    end
    checks++; if (fl !== 1'b1 || code !== 3'd3) begin failures++; $display("FAIL ex_code got=%0h/%0d exp=1/3", fl, code); end
    n = 0;
    repeat (50) begin
      if (ost) n++;
      step(1);
    end
    checks++; if (n !== 0) begin failures++; $display("FAIL ex_quiet got=%0d exp=0", n); end
  endtask

  task automatic test_watchdog();
    int l, f;
    bit ok;
    sel = 1'b1;
    do_reset();
    pulse_start();
    wait_launch(10, ok, l);
    checks++; if (!ok || idx !== 6'd0) begin failures++; $display("FAIL wd_launch got=%0d exp=0", idx); end
    f = -1;
    for (int i = 0; i < 200; i++) begin
      if (fl) begin
        f = cyc;
        break;
      end
      step(1);
    end
    checks++; if (f !== l + 101) begin failures++; $display("FAIL wd_time got=%0d exp=%0d", f, l + 101); end
    checks++; if (code !== 3'd4) begin failures++; $display("FAIL wd_code got=%0d exp=4", code); end
  endtask

  task automatic test_watchdog_edge();
    int l, at, d;
    bit ok;
    sel = 1'b1;
    do_reset();
    pulse_start();
    wait_launch(10, ok, l);
    send_done(100, 32'h0, d);
    wait_launch(1, ok, at);
    checks++; if (!ok || at !== l + 101) begin failures++; $display("FAIL wde_time got=%0d exp=%0d", at, l + 101); end
    checks++; if (idx !== 6'd8) begin failures++; $display("FAIL wde_index got=%0d exp=8", idx); end
    checks++; if (fl !== 1'b0) begin failures++; $display("FAIL wde_fail got=%0h exp=0", fl); end
  endtask

  task automatic test_status_err();
    logic [5:0] ei [9] = '{0, 8, 55, 41, 2, 3, 7, 55, 6};
    logic [31:0] ea [9] = '{0, 32'h1AA, 0, 32'h40FF8000, 0, 0,
      32'hABCD0000, 32'hABCD0000, 32'h2};
    logic [31:0] rs [9] = '{0, 32'h1AA, 32'h20, 32'hC0FF8000, 0,
      32'hABCD0000, 0, 32'h20, 32'h00080000};
    int at, d;
    bit ok;
    logic [5:0] ix;
    logic [31:0] ag;
    sel = 1'b1;
    do_reset();
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      run_cmd(50, rs[i], ok, ix, ag, at, d);
      checks++; if (!ok || ix !== ei[i] || ag !== ea[i]) begin failures++; $display("FAIL st_cmd%0d got=%0d/%0h exp=%0d/%0h", i, ix, ag, ei[i], ea[i]); end
    end
    checks++; if (fl !== 1'b1 || code !== 3'd5) begin failures++; $display("FAIL st_code got=%0h/%0d exp=1/5", fl, code); end
    checks++; if (sclk !== 1'b0 || rdy !== 1'b0) begin failures++; $display("FAIL st_selclk got=%0h/%0h exp=0/0", sclk, rdy); end
  endtask

  task automatic test_restart();
    logic [5:0] ei [9] = '{0, 8, 55, 41, 2, 3, 7, 55, 6};
    logic [31:0] rs [9] = '{0, 32'h1AA, 32'h20, 32'hC0FF8000, 0,
      32'h55550000, 0, 32'h20, 0};
    int at, d, n, t;
    bit ok;
    logic [5:0] ix;
    logic [31:0] ag;
    sel = 1'b1;
    do_reset();
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      if (ei[i] == 6'd2) begin
        wait_launch(50, ok, at);
        step(1);
        pulse_start();
        n = 0;
        repeat (3) begin
          if (ost) n++;
          step(1);
        end
        checks++; if (n !== 0 || idx !== 6'd2) begin failures++; $display("FAIL rs_ignore got=%0d/%0d exp=0/2", n, idx); end
        send_done(0, rs[i], d);
      end else begin
        run_cmd(50, rs[i], ok, ix, ag, at, d);
        checks++; if (!ok || ix !== ei[i]) begin failures++; $display("FAIL rs_cmd%0d got=%0d exp=%0d", i, ix, ei[i]); end
      end
    end
    checks++; if (rdy !== 1'b1 || rca !== 16'h5555) begin failures++; $display("FAIL rs_done got=%0h/%0h exp=1/5555", rdy, rca); end
    t = cyc;
    pulse_start();
    checks++; if (cyc !== t + 1 || ost !== 1'b1) begin failures++; $display("FAIL rs_launch got=%0h exp=1", ost); end
    checks++; if (rdy !== 1'b0 || sclk !== 1'b0) begin failures++; $display("FAIL rs_clear got=%0h/%0h exp=0/0", rdy, sclk); end
    checks++; if (idx !== 6'd0 || arg !== 32'd0 || rca !== 16'd0) begin failures++; $display("FAIL rs_cmd0 got=%0d/%0h/%0h exp=0/0/0", idx, arg, rca); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rs [3] = '{0, 32'h1AA, 32'h20};
    int at, d, n;
    bit ok;
    logic [5:0] ix;
    logic [31:0] ag;
    sel = 1'b1;
    do_reset();
    pulse_start();
    for (int i = 0; i < 3; i++) run_cmd(50, rs[i], ok, ix, ag, at, d);
    wait_launch(50, ok, at);
    checks++; if (!ok || idx !== 6'd41) begin failures++; $display("FAIL rm_a41 got=%0d exp=41", idx); end
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++; if ({ost, idx, arg, sclk, rdy, fl, code, rca} !== '0) begin failures++; $display("FAIL rm_zero got=%0h/%0d/%0h/%0h/%0h/%0h/%0d/%0h exp=0", ost, idx, arg, sclk, rdy, fl, code, rca); end
    send_done(0, 32'hC0FF8000, d);
    n = 0;
    repeat (10) begin
      if (ost || rdy || fl) n++;
      step(1);
    end
    checks++; if (n !== 0) begin failures++; $display("FAIL rm_ignore got=%0d exp=0", n); end
  endtask

  initial begin
    sel = 1'b0; rst = 1'b1; start = 1'b0; done = 1'b0; resp = '0;
    test_reset();
    test_nominal();
    test_cmd8_mismatch();
    test_acmd41_exhaust();
    test_watchdog();
    test_watchdog_edge();
    test_status_err();
    test_restart();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_init_seq.md
# sd_init_seq

SD card identification and bus-setup sequencer for the SD bus controller. It issues CMD0, CMD8, the CMD55/ACMD41 poll loop, CMD2, CMD3, CMD7, CMD55 and ACMD6 through the CMD-line driver handshake (start / index / argument / done / response). It checks each response, captures the card RCA, and enforces a per-command watchdog and a bounded ACMD41 retry count. On success it switches the clock-select output to the fast clock and reports ready to the transfer FSM.

## Interface
- RESP_TIMEOUT, 65535: cycles allowed from `ostart_cmd` to `icmd_done` before failing.
- ACMD41_TRIES, 1000: maximum ACMD41 attempts while the card reports busy.
- POLL_GAP, 36000: idle cycles between a busy ACMD41 response and the next CMD55 (1 ms at 36 MHz).
- iclk  in  1  system clock (36 MHz); the only clock.
- irst  in  1  reset, synchronous, active-high.
- istart  in  1  start or restart initialization; single-cycle pulse.
- ostart_cmd  out  1  one-cycle command launch pulse to the CMD driver.
- oindex  out  6  command index.
- oarg  out  32  command argument.
- icmd_done  in  1  one-cycle pulse; command (and response, if any) complete.
- iresp  in  32  response payload; valid in the `icmd_done` cycle.
- osel_clk  out  1  0 = 400 kHz init clock, 1 = fast clock.
- ordy  out  1  initialization complete; level.
- ofail  out  1  initialization failed; level.
- ofail_code  out  3  failure cause.
- orca  out  16  RCA published by the card.

## Operation
- Reset values: every output is 0, the state is IDLE and all counters are 0.
- States and commands:
  - IDLE
  - CMD0, arg 0
  - CMD8, arg 32'h000001AA
  - A55, CMD55, arg 0
  - ACMD41, index 41, arg 32'h40FF8000
  - GAP
  - CMD2, arg 0
  - CMD3, arg 0
  - CMD7, arg {rca,16'h0}
  - B55, CMD55, arg {rca,16'h0}
  - ACMD6, index 6, arg 32'h00000002
  - DONE
  - FAIL
- Each command state has two phases: a launch cycle (`ostart_cmd`=1) and a wait phase until `icmd_done`.
- Response checks, evaluated in the `icmd_done` cycle:
  - CMD0: none. Go to CMD8.
  - CMD8: iresp[11:0] must equal 12'h1AA, else FAIL with code 1.
  - A55 and B55: iresp[5] (APP_CMD) must be 1, else FAIL with code 2.
  - ACMD41, card ready (iresp[31]=1): go to CMD2.
  - ACMD41, card busy: increment the try counter. If the counter now equals ACMD41_TRIES, FAIL with code 3; otherwise go to GAP.
  - GAP: count POLL_GAP cycles, then go to A55.
  - CMD2: none.
  - CMD3: orca <= iresp[31:16].
  - CMD7 and ACMD6: iresp[31:19] must be 0, else FAIL with code 5.
  - ACMD6 success: go to DONE.
- Watchdog: cleared at every launch and increments during the wait phase. Reaching RESP_TIMEOUT goes to FAIL with code 4.
- DONE: osel_clk=1, ordy=1.
- FAIL: ofail=1 and ofail_code held; osel_clk stays 0.
- istart handling:
  - Accepted only in IDLE, DONE or FAIL.
  - Acceptance clears ordy, ofail, ofail_code, orca, osel_clk and the try counter, then enters CMD0.
  - Ignored in every other state.
- icmd_done received outside a wait phase is ignored.

## Timing
- Launch latency:
  - istart accepted at cycle t: ostart_cmd=1 at t+1 with oindex=0, oarg=0.
  - icmd_done at cycle d: the next ostart_cmd is at d+1.
  - After a busy ACMD41 the next ostart_cmd is at d+1+POLL_GAP, carrying CMD55.
- oindex and oarg are driven from the launch cycle through the `icmd_done` cycle, and stay unchanged until the next launch.
- Completion flags: ordy, osel_clk or ofail assert at d+1 after the final `icmd_done`, or at the cycle after the watchdog reaches RESP_TIMEOUT.
- Simultaneous events: if icmd_done and the watchdog terminal count occur in the same cycle, icmd_done wins.
- ostart_cmd is never high in two consecutive cycles.
- Reset mid-command: all outputs return to reset values on the next edge. A later icmd_done is ignored.
- Widths: the watchdog counter is 16 bits, the try counter 10 bits, the gap counter 16 bits.
- RESP_TIMEOUT, ACMD41_TRIES and POLL_GAP must be ≥1. With ACMD41_TRIES=1, one busy response fails immediately.

## Test plan
- Nominal card:
  - Stimulus: CMD8 resp 32'h000001AA; ACMD41 busy twice, then 32'hC0FF8000; CMD3 resp 32'h12340000; CMD7 and ACMD6 resp 0.
  - Required sequence: indices 0, 8, 55, 41, 55, 41, 55, 41, 2, 3, 7, 55, 6.
  - CMD7 arg = 32'h12340000.
  - Gaps of exactly 36000 cycles after each busy ACMD41.
  - End state: ordy=1, osel_clk=1, orca=16'h1234.
- CMD8 mismatch: CMD8 resp 32'h000001AB -> ofail=1, ofail_code=1, no further ostart_cmd.
- ACMD41 exhaustion: ACMD41_TRIES=3, POLL_GAP=4, card always busy -> exactly 3 ACMD41 launches, then ofail_code=3.
- Watchdog:
  - RESP_TIMEOUT=100 and no icmd_done after CMD0 -> ofail_code=4 asserted 101 cycles after the launch.
  - icmd_done landing on the terminal-count cycle -> proceeds to CMD8 with no failure.
- Status error: ACMD6 resp 32'h00080000 -> ofail_code=5 and osel_clk=0.
- Restart and reset:
  - istart during CMD2 wait -> ignored.
  - istart in DONE -> ordy=0, osel_clk=0, next launch is CMD0.
  - irst mid-ACMD41 -> all outputs 0 on the next cycle.
